// File: rtl/sentinel_match_bank.sv
// sentinel_match_bank: a table of ENTRY_COUNT programmable masked sentinels.
// Every valid input word is compared against all entries in parallel through
// a two-stage pipeline. The bank reports a per-entry match vector, an any-match
// flag, the lowest matching index, and per-entry sticky hit flags.
module sentinel_match_bank #(
   parameter int WORD_WIDTH  = 36,
   parameter int ENTRY_COUNT = 4,
   parameter int ADDR_WIDTH  = 2
) (
   input  logic                   clock,
   input  logic                   clear_n,
   input  logic                   cfg_wren,
   input  logic [ADDR_WIDTH-1:0]  cfg_addr,
   input  logic [WORD_WIDTH-1:0]  cfg_sentinel,
   input  logic [WORD_WIDTH-1:0]  cfg_mask,
   input  logic                   cfg_enable,
   input  logic                   in_valid,
   input  logic [WORD_WIDTH-1:0]  in,
   input  logic [ENTRY_COUNT-1:0] hit_clear,
   output logic                   out_valid,
   output logic [ENTRY_COUNT-1:0] match,
   output logic                   any_match,
   output logic [ADDR_WIDTH-1:0]  match_index,
   output logic [ENTRY_COUNT-1:0] hit_sticky
);

   // Sentinel table. Registers are used rather than RAM because reset must
   // clear every entry and all entries are read in the same cycle.
   logic [WORD_WIDTH-1:0]  sentinel_reg [ENTRY_COUNT];
   logic [WORD_WIDTH-1:0]  mask_reg     [ENTRY_COUNT];
   logic [ENTRY_COUNT-1:0] enable_reg;

   // Stage 1 holds the captured word.
   logic                   s1_valid_reg;
   logic [WORD_WIDTH-1:0]  s1_word_reg;

   // Stage 2 holds the compare results.
   logic [ENTRY_COUNT-1:0] match_next;
   logic [ADDR_WIDTH-1:0]  index_next;
   logic                   valid_reg;
   logic [ENTRY_COUNT-1:0] match_reg;
   logic                   any_reg;
   logic [ADDR_WIDTH-1:0]  index_reg;
   logic [ENTRY_COUNT-1:0] sticky_reg;

   // Table write: one entry per cycle. Addresses with no matching entry are dropped.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         for (int i = 0; i < ENTRY_COUNT; i++) begin
            sentinel_reg[i] <= '0;
            mask_reg[i]     <= '0;
         end
         enable_reg <= '0;
      end else if (cfg_wren) begin
         for (int i = 0; i < ENTRY_COUNT; i++) begin
            if (cfg_addr == ADDR_WIDTH'(i)) begin
               sentinel_reg[i] <= cfg_sentinel;
               mask_reg[i]     <= cfg_mask;
               enable_reg[i]   <= cfg_enable;
            end
         end
      end
   end

   // Stage 1: capture the incoming word and its valid flag.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         s1_valid_reg <= 1'b0;
         s1_word_reg  <= '0;
      end else begin
         s1_valid_reg <= in_valid;
         s1_word_reg  <= in;
      end
   end

   // Each entry compares the stage-1 word with the current table contents.
   // Gating with s1_valid_reg makes an invalid slot produce an all-zero result.
   for (genvar gi = 0; gi < ENTRY_COUNT; gi++) begin : g_cmp
      assign match_next[gi] = s1_valid_reg & enable_reg[gi] &
                              (((s1_word_reg ^ sentinel_reg[gi]) & mask_reg[gi]) == '0);
   end

   // Priority encoder: scan from high to low so that the lowest index wins.
   always_comb begin
      index_next = '0;
      for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
         if (match_next[i]) index_next = ADDR_WIDTH'(i);
      end
   end

   // Stage 2: register the results for the word that was in stage 1.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         valid_reg <= 1'b0;
         match_reg <= '0;
         any_reg   <= 1'b0;
         index_reg <= '0;
      end else begin
         valid_reg <= s1_valid_reg;
         match_reg <= match_next;
         any_reg   <= |match_next;
         index_reg <= index_next;
      end
   end

   // Sticky hits: a new hit is ORed in after the clear, so a set wins over a clear.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         sticky_reg <= '0;
      end else begin
         sticky_reg <= (sticky_reg & ~hit_clear) | (valid_reg ? match_reg : '0);
      end
   end

   assign out_valid   = valid_reg;
   assign match       = match_reg;
   assign any_match   = any_reg;
   assign match_index = index_reg;
   assign hit_sticky  = sticky_reg;

endmodule

// File: tb/tb_sentinel_match_bank.sv
// Directed bench for sentinel_match_bank.
// Each table row is one clock cycle. Its expected fields are the outputs
// observed just after that cycle's rising edge. Those outputs are the result
// of the word from the previous row, and the sticky flags include the hits
// from two rows back.
module tb_sentinel_match_bank;

   localparam int WW = 36;
   localparam int EC = 4;
   localparam int AW = 2;
   localparam logic [WW-1:0] ONES = {WW{1'b1}};

   logic          clock = 1'b0;
   logic          clear_n;
   logic          cfg_wren;
   logic [AW-1:0] cfg_addr;
   logic [WW-1:0] cfg_sentinel;
   logic [WW-1:0] cfg_mask;
   logic          cfg_enable;
   logic          in_valid;
   logic [WW-1:0] din;
   logic [EC-1:0] hit_clear;
   logic          out_valid;
   logic [EC-1:0] match;
   logic          any_match;
   logic [AW-1:0] match_index;
   logic [EC-1:0] hit_sticky;

   int n_checks = 0;
   int n_fail   = 0;

   sentinel_match_bank #(.WORD_WIDTH(WW), .ENTRY_COUNT(EC), .ADDR_WIDTH(AW)) dut (
      .clock(clock), .clear_n(clear_n),
      .cfg_wren(cfg_wren), .cfg_addr(cfg_addr), .cfg_sentinel(cfg_sentinel),
      .cfg_mask(cfg_mask), .cfg_enable(cfg_enable),
      .in_valid(in_valid), .in(din), .hit_clear(hit_clear),
      .out_valid(out_valid), .match(match), .any_match(any_match),
      .match_index(match_index), .hit_sticky(hit_sticky)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          wren;
      logic [AW-1:0] addr;
      logic [WW-1:0] sent;
      logic [WW-1:0] mask;
      logic          en;
      logic          iv;
      logic [WW-1:0] word;
      logic [EC-1:0] hc;
      logic          e_ov;
      logic [EC-1:0] e_m;
      logic          e_any;
      logic [AW-1:0] e_idx;
      logic [EC-1:0] e_st;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one cycle. Inputs are then driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      cfg_wren = 1'b0; cfg_addr = '0; cfg_sentinel = '0; cfg_mask = '0; cfg_enable = 1'b0;
      in_valid = 1'b0; din = '0; hit_clear = '0;
   endtask

   initial begin
      // Row fields: wren addr sentinel mask en | iv word hit_clear | exp: ov match any idx sticky
      vecs[0]  = '{1, 2'd1, 36'h123456789, ONES,          1, 1, 36'h123456789, 4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0000};
      vecs[1]  = '{0, 2'd0, 36'h0,         36'h0,         0, 1, 36'h123456788, 4'b0000, 1, 4'b0010, 1, 2'd1, 4'b0000};
      vecs[2]  = '{1, 2'd1, 36'h123456789, 36'hFFFFFFFF0, 1, 1, 36'h123456788, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0010};
      vecs[3]  = '{0, 2'd0, 36'h0,         36'h0,         0, 0, 36'h0,         4'b0000, 1, 4'b0010, 1, 2'd1, 4'b0010};
      vecs[4]  = '{0, 2'd0, 36'h0,         36'h0,         0, 0, 36'h0,         4'b0010, 0, 4'b0000, 0, 2'd0, 4'b0010};
      vecs[5]  = '{0, 2'd0, 36'h0,         36'h0,         0, 0, 36'h0,         4'b0010, 0, 4'b0000, 0, 2'd0, 4'b0000};
      vecs[6]  = '{1, 2'd0, ONES,          36'h0,         1, 0, 36'h0,         4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0000};
      vecs[7]  = '{1, 2'd2, 36'hABC,       ONES,          1, 1, 36'hABC,       4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0000};
      vecs[8]  = '{0, 2'd0, 36'h0,         36'h0,         0, 0, 36'h0,         4'b0000, 1, 4'b0101, 1, 2'd0, 4'b0000};
      vecs[9]  = '{1, 2'd0, 36'h0,         36'h0,         0, 1, 36'hABC,       4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0101};
      vecs[10] = '{0, 2'd0, 36'h0,         36'h0,         0, 0, 36'h0,         4'b0001, 1, 4'b0100, 1, 2'd2, 4'b0100};
      vecs[11] = '{0, 2'd0, 36'h0,         36'h0,         0, 1, 36'h55,        4'b0000, 0, 4'b0000, 0, 2'd0, 4'b0100};
      vecs[12] = '{1, 2'd3, 36'h55,        ONES,          1, 1, 36'h55,        4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0100};
      vecs[13] = '{0, 2'd0, 36'h0,         36'h0,         0, 1, 36'h0,         4'b0000, 1, 4'b1000, 1, 2'd3, 4'b0100};
      vecs[14] = '{0, 2'd0, 36'h0,         36'h0,         0, 1, 36'h55,        4'b0000, 1, 4'b0000, 0, 2'd0, 4'b1100};
      vecs[15] = '{0, 2'd0, 36'h0,         36'h0,         0, 0, 36'h0,         4'b0000, 1, 4'b1000, 1, 2'd3, 4'b1100};
      vecs[16] = '{0, 2'd0, 36'h0,         36'h0,         0, 0, 36'h0,         4'b1111, 0, 4'b0000, 0, 2'd0, 4'b1000};
      vecs[17] = '{0, 2'd0, 36'h0,         36'h0,         0, 0, 36'h0,         4'b1000, 0, 4'b0000, 0, 2'd0, 4'b0000};

      // Hold reset while a valid word is presented. Nothing may come out.
      idle_inputs();
      clear_n  = 1'b0;
      in_valid = 1'b1;
      repeat (3) step();
      chk("reset out_valid",   64'(out_valid),   64'(0));
      chk("reset match",       64'(match),       64'(0));
      chk("reset any_match",   64'(any_match),   64'(0));
      chk("reset match_index", 64'(match_index), 64'(0));
      chk("reset hit_sticky",  64'(hit_sticky),  64'(0));
      $display("reset: ov=%0b match=%b sticky=%b", out_valid, match, hit_sticky);

      // Release reset with in=0. All entries are disabled, so the result is valid with no match.
      clear_n = 1'b1; in_valid = 1'b1; din = '0;
      step();
      in_valid = 1'b0;
      step();
      chk("post-reset out_valid", 64'(out_valid), 64'(1));
      chk("post-reset match",     64'(match),     64'(0));
      chk("post-reset any_match", 64'(any_match), 64'(0));
      $display("post-reset word 0: ov=%0b match=%b", out_valid, match);
      step();
      chk("post-reset gap out_valid", 64'(out_valid), 64'(0));

      // Table-driven section.
      for (int i = 0; i < 18; i++) begin
         cfg_wren = vecs[i].wren; cfg_addr = vecs[i].addr; cfg_sentinel = vecs[i].sent;
         cfg_mask = vecs[i].mask; cfg_enable = vecs[i].en;
         in_valid = vecs[i].iv; din = vecs[i].word; hit_clear = vecs[i].hc;
         step();
         chk($sformatf("v%0d out_valid", i),   64'(out_valid),   64'(vecs[i].e_ov));
         chk($sformatf("v%0d match", i),       64'(match),       64'(vecs[i].e_m));
         chk($sformatf("v%0d any_match", i),   64'(any_match),   64'(vecs[i].e_any));
         chk($sformatf("v%0d match_index", i), 64'(match_index), 64'(vecs[i].e_idx));
         chk($sformatf("v%0d hit_sticky", i),  64'(hit_sticky),  64'(vecs[i].e_st));
         $display("v%0d: wr=%0b iv=%0b in=%h hc=%b -> ov=%0b match=%b any=%0b idx=%0d sticky=%b",
                  i, vecs[i].wren, vecs[i].iv, vecs[i].word, vecs[i].hc,
                  out_valid, match, any_match, match_index, hit_sticky);
      end

      // Mid-stream reset. Two 0x55 words are in flight, and reset also overrides a table write.
      idle_inputs();
      in_valid = 1'b1; din = 36'h55;
      step();
      step();
      chk("pre-reset out_valid", 64'(out_valid), 64'(1));
      chk("pre-reset match",     64'(match),     64'(4'b1000));
      clear_n = 1'b0; in_valid = 1'b0;
      cfg_wren = 1'b1; cfg_addr = 2'd3; cfg_sentinel = 36'h55; cfg_mask = ONES; cfg_enable = 1'b1;
      hit_clear = '0;
      step();
      chk("mid-reset out_valid",  64'(out_valid),  64'(0));
      chk("mid-reset hit_sticky", 64'(hit_sticky), 64'(0));
      idle_inputs();
      clear_n = 1'b1;
      step();
      chk("flushed out_valid", 64'(out_valid), 64'(0));
      chk("flushed match",     64'(match),     64'(0));
      $display("mid-stream reset: ov=%0b match=%b sticky=%b", out_valid, match, hit_sticky);

      // Entry 3 must still be cleared, because the write made during reset was discarded.
      in_valid = 1'b1; din = 36'h55;
      step();
      in_valid = 1'b0;
      step();
      chk("after-reset table out_valid", 64'(out_valid), 64'(1));
      chk("after-reset table match",     64'(match),     64'(0));
      $display("after reset 0x55: ov=%0b match=%b", out_valid, match);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
